// File: rtl/mcu_alu_sequencer.sv
// Fetch/decode/execute sequencer between the instruction/data memory ports and the 8-bit ALU.
// Optional build macro MCU_SINGLE_STEP_EN adds the step port and makes IDLE wait for step=1.
//
// state  | meaning
// IDLE   | between instructions, no requests
// FETCH  | imem_req high until imem_ack, load ir, bump pc
// DECODE | classify ir, resolve jumps
// MEM_RD | ALUM operand read from data memory
// EXEC   | ALU enabled, capture result and flags
// MEM_WR | STORE of acc to data memory
// HALT   | stopped until reset

module mcu_alu_sequencer (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [7:0]  dmem_addr,
   output logic [7:0]  dmem_wdata,
   input  logic        dmem_ack,
   input  logic [7:0]  dmem_rdata,
   output logic        alu_enable,
   output logic [3:0]  alu_mode,
   output logic [7:0]  alu_op1,
   output logic [7:0]  alu_op2,
   input  logic [7:0]  alu_result,
   input  logic [3:0]  alu_flag,
   output logic [7:0]  acc,
   output logic [3:0]  flags,
   output logic [7:0]  pc,
   output logic        halted
`ifdef MCU_SINGLE_STEP_EN
   ,
   input  logic        step
`endif
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_MEM_RD = 3'd3;
   localparam logic [2:0] S_EXEC   = 3'd4;
   localparam logic [2:0] S_MEM_WR = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [3:0] C_ALUI  = 4'd0;
   localparam logic [3:0] C_ALUM  = 4'd1;
   localparam logic [3:0] C_STORE = 4'd2;
   localparam logic [3:0] C_JMP   = 4'd3;
   localparam logic [3:0] C_JZ    = 4'd4;
   localparam logic [3:0] C_JC    = 4'd5;
   localparam logic [3:0] C_HALT  = 4'd6;

   logic [2:0]  state;
   logic [15:0] ir;
   logic [7:0]  op2_q;
   logic [3:0]  cls;
   logic        go;

   assign cls = ir[15:12];

`ifdef MCU_SINGLE_STEP_EN
   assign go = step;
`else
   assign go = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         pc    <= 8'h00;
         acc   <= 8'h00;
         flags <= 4'b0000;
         ir    <= 16'h0000;
         op2_q <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (go) state <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  ir    <= imem_data;
                  pc    <= pc + 8'd1;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (cls)
                  C_ALUI:  state <= S_EXEC;
                  C_ALUM:  state <= S_MEM_RD;
                  C_STORE: state <= S_MEM_WR;
                  C_JMP: begin
                     pc    <= ir[7:0];
                     state <= S_IDLE;
                  end
                  C_JZ: begin
                     if (flags[3]) pc <= ir[7:0];
                     state <= S_IDLE;
                  end
                  C_JC: begin
                     if (flags[2]) pc <= ir[7:0];
                     state <= S_IDLE;
                  end
                  C_HALT:  state <= S_HALT;
                  default: state <= S_IDLE;
               endcase
            end
            S_MEM_RD: begin
               if (dmem_ack) begin
                  op2_q <= dmem_rdata;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               acc   <= alu_result;
               flags <= alu_flag;
               state <= S_IDLE;
            end
            S_MEM_WR: begin
               if (dmem_ack) state <= S_IDLE;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Strobes are masked by rst so they fall in the very cycle reset is raised.
   assign imem_req   = !rst && (state == S_FETCH);
   assign dmem_req   = !rst && ((state == S_MEM_RD) || (state == S_MEM_WR));
   assign dmem_we    = !rst && (state == S_MEM_WR);
   assign alu_enable = !rst && (state == S_EXEC);
   assign halted     = !rst && (state == S_HALT);

   assign imem_addr  = pc;
   assign dmem_addr  = ir[7:0];
   assign dmem_wdata = acc;
   assign alu_mode   = ir[11:8];
   assign alu_op1    = acc;
   assign alu_op2    = (cls == C_ALUM) ? op2_q : ir[7:0];

endmodule
